// File: rtl/finn_rtl_krnl_final_example_rd_burst_ctrl_if.sv
// AXI4 read-address channel plus the R-channel last-beat handshake strobe
// exchanged between the burst controller and the read master.
interface finn_rtl_krnl_final_example_rd_burst_ctrl_if #(
    parameter int C_ADDR_WIDTH = 64
);
    logic                    arvalid;
    logic                    arready;
    logic [C_ADDR_WIDTH-1:0] araddr;
    logic [7:0]              arlen;
    logic                    r_last_hs;

    modport master (
        output arvalid,
        output araddr,
        output arlen,
        input  arready,
        input  r_last_hs
    );

    modport slave (
        input  arvalid,
        input  araddr,
        input  arlen,
        output arready,
        output r_last_hs
    );
endinterface

// File: rtl/finn_rtl_krnl_final_example_rd_burst_ctrl.sv
// Splits a byte-sized read request into fixed-length AXI4 AR bursts and
// throttles them with an outstanding-burst counter fed by R last beats.
module finn_rtl_krnl_final_example_rd_burst_ctrl #(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_XFER_SIZE_WIDTH = 32,
    parameter int C_BYTES_PER_BEAT  = 64,
    parameter int C_BURST_LEN       = 16,
    parameter int C_MAX_OUTSTANDING = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
    output logic                         ctrl_done,
    output logic                         busy,
    finn_rtl_krnl_final_example_rd_burst_ctrl_if.master axi
);
    localparam int XW       = C_XFER_SIZE_WIDTH;
    localparam int OW       = $clog2(C_MAX_OUTSTANDING + 1);
    localparam int LOG2_BPB = $clog2(C_BYTES_PER_BEAT);
    localparam int LOG2_BL  = $clog2(C_BURST_LEN);

    localparam logic [XW-1:0]           BPB_MASK   = XW'(C_BYTES_PER_BEAT - 1);
    localparam logic [XW-1:0]           BL_MASK    = XW'(C_BURST_LEN - 1);
    localparam logic [7:0]              FULL_ARLEN = 8'(C_BURST_LEN - 1);
    localparam logic [C_ADDR_WIDTH-1:0] BURST_STEP = C_ADDR_WIDTH'(C_BURST_LEN * C_BYTES_PER_BEAT);
    localparam logic [OW-1:0]           MAX_OUT    = OW'(C_MAX_OUTSTANDING);

    typedef enum logic [2:0] {IDLE, PREP, ISSUE, DRAIN, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [C_ADDR_WIDTH-1:0] base_reg;
    logic [XW-1:0]           size_reg;
    logic [XW-1:0]           bursts_reg;
    logic [XW-1:0]           rem_reg;
    logic [XW-1:0]           completed_reg;
    logic [7:0]              last_arlen_reg;
    logic [C_ADDR_WIDTH-1:0] araddr_reg;
    logic [7:0]              arlen_reg;
    logic [OW-1:0]           outstanding_reg;

    logic [XW-1:0] beats_calc;
    logic [XW-1:0] bursts_calc;
    logic [XW-1:0] tail_calc;
    logic [7:0]    last_arlen_calc;
    logic          ar_hs;
    logic          r_dec;

    // Ceiling divisions by powers of two: shift, then add one if any remainder bit is set.
    assign beats_calc      = (size_reg >> LOG2_BPB) + XW'(|(size_reg & BPB_MASK));
    assign bursts_calc     = (beats_calc >> LOG2_BL) + XW'(|(beats_calc & BL_MASK));
    assign tail_calc       = beats_calc & BL_MASK;
    assign last_arlen_calc = (tail_calc == '0) ? FULL_ARLEN : 8'(tail_calc - XW'(1));

    assign axi.arvalid = (state_reg == ISSUE) && (outstanding_reg < MAX_OUT);
    assign axi.araddr  = araddr_reg;
    assign axi.arlen   = arlen_reg;
    assign busy        = (state_reg != IDLE);
    assign ctrl_done   = (state_reg == DONE);

    assign ar_hs = axi.arvalid & axi.arready;
    // Last beats arriving with nothing in flight (e.g. stragglers after reset) are dropped.
    assign r_dec = axi.r_last_hs && (outstanding_reg != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (ctrl_start) state_next = PREP;
            PREP:    state_next = (bursts_calc == '0) ? DONE : ISSUE;
            ISSUE:   if (ar_hs && rem_reg == XW'(1)) state_next = DRAIN;
            DRAIN:   if (completed_reg == bursts_reg && outstanding_reg == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_reg        <= '0;
            size_reg        <= '0;
            bursts_reg      <= '0;
            rem_reg         <= '0;
            completed_reg   <= '0;
            last_arlen_reg  <= '0;
            araddr_reg      <= '0;
            arlen_reg       <= '0;
            outstanding_reg <= '0;
        end else begin
            if (state_reg == IDLE && ctrl_start) begin
                base_reg      <= ctrl_addr_offset;
                size_reg      <= ctrl_xfer_size_in_bytes;
                completed_reg <= '0;
            end else if (r_dec) begin
                completed_reg <= completed_reg + XW'(1);
            end

            if (state_reg == PREP) begin
                bursts_reg     <= bursts_calc;
                rem_reg        <= bursts_calc;
                last_arlen_reg <= last_arlen_calc;
                araddr_reg     <= base_reg;
                arlen_reg      <= (bursts_calc == XW'(1)) ? last_arlen_calc : FULL_ARLEN;
            end

            // Advance to the next burst right on the handshake so it can go out back-to-back.
            if (state_reg == ISSUE && ar_hs) begin
                rem_reg    <= rem_reg - XW'(1);
                araddr_reg <= araddr_reg + BURST_STEP;
                arlen_reg  <= (rem_reg == XW'(2)) ? last_arlen_reg : FULL_ARLEN;
            end

            case ({ar_hs, r_dec})
                2'b10:   outstanding_reg <= outstanding_reg + OW'(1);
                2'b01:   outstanding_reg <= outstanding_reg - OW'(1);
                default: outstanding_reg <= outstanding_reg;
            endcase
        end
    end
endmodule

// File: tb/tb_finn_rtl_krnl_final_example_rd_burst_ctrl.sv
// Directed bench: default instance for burst splitting/timing/reset, and a
// second instance with two outstanding bursts for throttling.
module tb_finn_rtl_krnl_final_example_rd_burst_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_start, a_done, a_busy;
    logic [63:0] a_addr;
    logic [31:0] a_size;
    logic        b_start, b_done, b_busy;
    logic [63:0] b_addr;
    logic [31:0] b_size;

    finn_rtl_krnl_final_example_rd_burst_ctrl_if #(.C_ADDR_WIDTH(64)) ifa ();
    finn_rtl_krnl_final_example_rd_burst_ctrl_if #(.C_ADDR_WIDTH(64)) ifb ();

    finn_rtl_krnl_final_example_rd_burst_ctrl u_a (
        .clk(clk), .rst(rst), .ctrl_start(a_start), .ctrl_addr_offset(a_addr),
        .ctrl_xfer_size_in_bytes(a_size), .ctrl_done(a_done), .busy(a_busy), .axi(ifa)
    );

    finn_rtl_krnl_final_example_rd_burst_ctrl #(.C_MAX_OUTSTANDING(2)) u_b (
        .clk(clk), .rst(rst), .ctrl_start(b_start), .ctrl_addr_offset(b_addr),
        .ctrl_xfer_size_in_bytes(b_size), .ctrl_done(b_done), .busy(b_busy), .axi(ifb)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_a = 0, hs_b = 0, dn_a = 0, dn_b = 0, dn_cyc_a = 0;
    int rl_a = 0;
    logic [63:0] log_addr_a [64];
    logic [7:0]  log_len_a  [64];
    int          log_cyc_a  [64];
    logic [63:0] log_addr_b [64];
    logic [7:0]  log_len_b  [64];

    // Passive monitor: records every AR handshake and done pulse with its edge number.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ifa.arvalid && ifa.arready) begin
            log_addr_a[hs_a[5:0]] <= ifa.araddr;
            log_len_a[hs_a[5:0]]  <= ifa.arlen;
            log_cyc_a[hs_a[5:0]]  <= cyc;
            hs_a <= hs_a + 1;
        end
        if (ifb.arvalid && ifb.arready) begin
            log_addr_b[hs_b[5:0]] <= ifb.araddr;
            log_len_b[hs_b[5:0]]  <= ifb.arlen;
            hs_b <= hs_b + 1;
        end
        if (a_done) begin
            dn_a     <= dn_a + 1;
            dn_cyc_a <= cyc;
        end
        if (b_done) dn_b <= dn_b + 1;
    end

    // One clock: auto_a returns one R last beat per outstanding AR of instance a.
    task automatic step(input bit auto_a, input bit r_a, input bit r_b);
        if (auto_a && hs_a > rl_a) begin
            ifa.r_last_hs = 1'b1;
            rl_a++;
        end else begin
            ifa.r_last_hs = r_a;
        end
        ifb.r_last_hs = r_b;
        @(negedge clk);
    endtask

    task automatic wait_done_a(input int d0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (dn_a > d0) begin
                ok = 1'b1;
                break;
            end
            step(1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_start = 1'b0; a_addr = '0; a_size = '0;
        b_start = 1'b0; b_addr = '0; b_size = '0;
        ifa.arready = 1'b0; ifa.r_last_hs = 1'b0;
        ifb.arready = 1'b0; ifb.r_last_hs = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        if ({a_busy, a_done, ifa.arvalid} !== 3'b000) begin errors++; $display("FAIL reset_a_ctl: busy/done/arvalid=%b expected 000", {a_busy, a_done, ifa.arvalid}); end
        checks++;
        if (ifa.araddr !== 64'h0 || ifa.arlen !== 8'h0) begin errors++; $display("FAIL reset_a_ar: araddr=%h arlen=%h expected 0/0", ifa.araddr, ifa.arlen); end
        checks++;
        if ({b_busy, b_done, ifb.arvalid} !== 3'b000) begin errors++; $display("FAIL reset_b_ctl: busy/done/arvalid=%b expected 000", {b_busy, b_done, ifb.arvalid}); end
        checks++;
        $display("reset: done");
    endtask

    task automatic test_full_bursts();
        int n, h0, d0, idx;
        bit ok;
        ifa.arready = 1'b1; rl_a = hs_a; h0 = hs_a; d0 = dn_a;
        a_addr = 64'h1000; a_size = 32'd4096; a_start = 1'b1; n = cyc;
        step(1'b1, 1'b0, 1'b0);
        a_start = 1'b0;
        if (a_busy !== 1'b1 || ifa.arvalid !== 1'b0) begin errors++; $display("FAIL full_prep: busy=%b arvalid=%b expected 1/0", a_busy, ifa.arvalid); end
        checks++;
        step(1'b1, 1'b0, 1'b0);
        if (ifa.arvalid !== 1'b1 || ifa.araddr !== 64'h1000 || ifa.arlen !== 8'd15) begin errors++; $display("FAIL full_first_ar: arvalid=%b araddr=%h arlen=%0d expected 1/1000/15", ifa.arvalid, ifa.araddr, ifa.arlen); end
        checks++;
        wait_done_a(d0, ok);
        if (!ok) begin errors++; $display("FAIL full_timeout: no ctrl_done within 200 cycles"); end
        checks++;
        if (hs_a - h0 !== 4) begin errors++; $display("FAIL full_count: %0d ARs expected 4", hs_a - h0); end
        checks++;
        for (int k = 0; k < 4; k++) begin
            idx = (h0 + k) & 63;
            if (log_addr_a[idx] !== 64'h1000 + 64'(k) * 64'h400 || log_len_a[idx] !== 8'd15 || log_cyc_a[idx] !== n + 2 + k) begin
                errors++;
                $display("FAIL full_burst%0d: araddr=%h arlen=%0d edge=%0d expected %h/15/%0d", k, log_addr_a[idx], log_len_a[idx], log_cyc_a[idx], 64'h1000 + 64'(k) * 64'h400, n + 2 + k);
            end
            checks++;
        end
        if (dn_cyc_a !== n + 8 || a_busy !== 1'b0) begin errors++; $display("FAIL full_done_time: done edge=%0d busy=%b expected %0d/0", dn_cyc_a, a_busy, n + 8); end
        checks++;
        repeat (3) step(1'b1, 1'b0, 1'b0);
        if (dn_a - d0 !== 1) begin errors++; $display("FAIL full_done_count: %0d expected 1", dn_a - d0); end
        checks++;
        $display("full_bursts: 4096 bytes @1000 -> %0d ARs", hs_a - h0);
    endtask

    task automatic test_round_up();
        int h0, d0;
        bit ok;
        ifa.arready = 1'b1; rl_a = hs_a;
        h0 = hs_a; d0 = dn_a;
        a_addr = 64'h2000; a_size = 32'd1000; a_start = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        a_start = 1'b0;
        wait_done_a(d0, ok);
        if (!ok || hs_a - h0 !== 1) begin errors++; $display("FAIL round16_count: ok=%b ARs=%0d expected 1/1", ok, hs_a - h0); end
        checks++;
        if (log_addr_a[h0 & 63] !== 64'h2000 || log_len_a[h0 & 63] !== 8'd15) begin errors++; $display("FAIL round16_ar: araddr=%h arlen=%0d expected 2000/15", log_addr_a[h0 & 63], log_len_a[h0 & 63]); end
        checks++;
        $display("round_up: 1000 bytes -> arlen %0d", log_len_a[h0 & 63]);
        step(1'b1, 1'b0, 1'b0);
        h0 = hs_a; d0 = dn_a;
        a_addr = 64'h4000; a_size = 32'd1088; a_start = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        a_start = 1'b0;
        wait_done_a(d0, ok);
        if (!ok || hs_a - h0 !== 2) begin errors++; $display("FAIL round17_count: ok=%b ARs=%0d expected 1/2", ok, hs_a - h0); end
        checks++;
        if (log_len_a[h0 & 63] !== 8'd15 || log_len_a[(h0 + 1) & 63] !== 8'd0) begin errors++; $display("FAIL round17_len: arlen=%0d,%0d expected 15,0", log_len_a[h0 & 63], log_len_a[(h0 + 1) & 63]); end
        checks++;
        if (log_addr_a[(h0 + 1) & 63] !== 64'h4400) begin errors++; $display("FAIL round17_addr: araddr=%h expected 4400", log_addr_a[(h0 + 1) & 63]); end
        checks++;
        $display("round_up: 1088 bytes -> %0d ARs", hs_a - h0);
        step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_arready_stall();
        int h0, d0;
        bit ok;
        ifa.arready = 1'b0; rl_a = hs_a; h0 = hs_a; d0 = dn_a;
        a_addr = 64'h8000; a_size = 32'd2048; a_start = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        a_start = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        ifa.arready = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        ifa.arready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (ifa.arvalid !== 1'b1 || ifa.araddr !== 64'h8400 || ifa.arlen !== 8'd15) begin errors++; $display("FAIL stall_hold%0d: arvalid=%b araddr=%h arlen=%0d expected 1/8400/15", i, ifa.arvalid, ifa.araddr, ifa.arlen); end
            checks++;
            step(1'b1, 1'b0, 1'b0);
        end
        ifa.arready = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        if (hs_a - h0 !== 2) begin errors++; $display("FAIL stall_release: %0d ARs expected 2", hs_a - h0); end
        checks++;
        wait_done_a(d0, ok);
        if (!ok) begin errors++; $display("FAIL stall_timeout: no ctrl_done"); end
        checks++;
        $display("arready_stall: burst 1 held 5 cycles, %0d ARs", hs_a - h0);
        step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_zero_and_ignore();
        int n, h0, d0;
        bit ok;
        ifa.arready = 1'b1; rl_a = hs_a; h0 = hs_a; d0 = dn_a;
        a_addr = 64'h5000; a_size = 32'd0; a_start = 1'b1; n = cyc;
        step(1'b1, 1'b0, 1'b0);
        if (a_busy !== 1'b1 || a_done !== 1'b0) begin errors++; $display("FAIL zero_prep: busy=%b done=%b expected 1/0", a_busy, a_done); end
        checks++;
        step(1'b1, 1'b0, 1'b0);
        if (a_done !== 1'b1 || ifa.arvalid !== 1'b0) begin errors++; $display("FAIL zero_done: done=%b arvalid=%b expected 1/0", a_done, ifa.arvalid); end
        checks++;
        step(1'b1, 1'b0, 1'b0);
        a_start = 1'b0;
        if (a_busy !== 1'b0 || dn_cyc_a !== n + 2) begin errors++; $display("FAIL zero_idle: busy=%b done edge=%0d expected 0/%0d", a_busy, dn_cyc_a, n + 2); end
        checks++;
        repeat (3) step(1'b1, 1'b0, 1'b0);
        if (dn_a - d0 !== 1 || hs_a - h0 !== 0) begin errors++; $display("FAIL zero_counts: done=%0d ARs=%0d expected 1/0", dn_a - d0, hs_a - h0); end
        checks++;
        $display("zero_size: done pulses=%0d ARs=%0d", dn_a - d0, hs_a - h0);

        ifa.arready = 1'b0; h0 = hs_a; d0 = dn_a;
        a_addr = 64'h10000; a_size = 32'd1024; a_start = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        a_start = 1'b0;
        repeat (2) step(1'b1, 1'b0, 1'b0);
        a_addr = 64'h99000; a_size = 32'd4096; a_start = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        a_start = 1'b0; ifa.arready = 1'b1;
        wait_done_a(d0, ok);
        repeat (4) step(1'b1, 1'b0, 1'b0);
        if (!ok || hs_a - h0 !== 1 || log_addr_a[h0 & 63] !== 64'h10000) begin errors++; $display("FAIL ignore_ar: ok=%b ARs=%0d araddr=%h expected 1/1/10000", ok, hs_a - h0, log_addr_a[h0 & 63]); end
        checks++;
        if (dn_a - d0 !== 1 || a_busy !== 1'b0) begin errors++; $display("FAIL ignore_done: done=%0d busy=%b expected 1/0", dn_a - d0, a_busy); end
        checks++;
        $display("ignore_busy_start: ARs=%0d done=%0d", hs_a - h0, dn_a - d0);
    endtask

    task automatic test_throttle();
        int h0, d0;
        ifb.arready = 1'b1; h0 = hs_b; d0 = dn_b;
        b_addr = 64'h0; b_size = 32'd8192; b_start = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        b_start = 1'b0;
        repeat (10) step(1'b0, 1'b0, 1'b0);
        if (hs_b - h0 !== 2 || ifb.arvalid !== 1'b0) begin errors++; $display("FAIL throttle_limit: ARs=%0d arvalid=%b expected 2/0", hs_b - h0, ifb.arvalid); end
        checks++;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b1);
            repeat (3) step(1'b0, 1'b0, 1'b0);
            if (hs_b - h0 !== 3 + i || ifb.arvalid !== 1'b0) begin errors++; $display("FAIL throttle_release%0d: ARs=%0d arvalid=%b expected %0d/0", i, hs_b - h0, ifb.arvalid, 3 + i); end
            checks++;
        end
        repeat (2) begin
            step(1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            if (dn_b > d0) break;
            step(1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0);
        if (dn_b - d0 !== 1 || b_busy !== 1'b0) begin errors++; $display("FAIL throttle_done: done=%0d busy=%b expected 1/0", dn_b - d0, b_busy); end
        checks++;
        if (log_addr_b[(h0 + 7) & 63] !== 64'h1C00 || log_len_b[(h0 + 7) & 63] !== 8'd15) begin errors++; $display("FAIL throttle_last_ar: araddr=%h arlen=%0d expected 1c00/15", log_addr_b[(h0 + 7) & 63], log_len_b[(h0 + 7) & 63]); end
        checks++;
        $display("throttle: 8192 bytes, max 2 outstanding -> %0d ARs", hs_b - h0);
    endtask

    task automatic test_reset_mid();
        int h0, d0;
        bit ok;
        ifa.arready = 1'b1; rl_a = hs_a; h0 = hs_a; d0 = dn_a;
        a_addr = 64'h20000; a_size = 32'd3072; a_start = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        a_start = 1'b0;
        repeat (10) step(1'b0, 1'b0, 1'b0);
        if (hs_a - h0 !== 3 || a_busy !== 1'b1 || ifa.arvalid !== 1'b0) begin errors++; $display("FAIL rstmid_drain: ARs=%0d busy=%b arvalid=%b expected 3/1/0", hs_a - h0, a_busy, ifa.arvalid); end
        checks++;
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        if (a_busy !== 1'b0 || ifa.arvalid !== 1'b0 || ifa.araddr !== 64'h0 || ifa.arlen !== 8'h0) begin errors++; $display("FAIL rstmid_outputs: busy=%b arvalid=%b araddr=%h arlen=%h expected 0/0/0/0", a_busy, ifa.arvalid, ifa.araddr, ifa.arlen); end
        checks++;
        if (u_a.outstanding_reg !== '0) begin errors++; $display("FAIL rstmid_outstanding: %0d expected 0", u_a.outstanding_reg); end
        checks++;
        repeat (3) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        if (dn_a !== d0 || u_a.outstanding_reg !== '0) begin errors++; $display("FAIL rstmid_stale_r: done=%0d outstanding=%0d expected 0/0", dn_a - d0, u_a.outstanding_reg); end
        checks++;
        rl_a = hs_a; h0 = hs_a; d0 = dn_a;
        a_addr = 64'h30000; a_size = 32'd1024; a_start = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        a_start = 1'b0;
        wait_done_a(d0, ok);
        repeat (2) step(1'b1, 1'b0, 1'b0);
        if (!ok || hs_a - h0 !== 1 || log_addr_a[h0 & 63] !== 64'h30000 || log_len_a[h0 & 63] !== 8'd15) begin errors++; $display("FAIL rstmid_after: ok=%b ARs=%0d araddr=%h arlen=%0d expected 1/1/30000/15", ok, hs_a - h0, log_addr_a[h0 & 63], log_len_a[h0 & 63]); end
        checks++;
        if (dn_a - d0 !== 1) begin errors++; $display("FAIL rstmid_done: %0d expected 1", dn_a - d0); end
        checks++;
        $display("reset_mid: post-reset request ARs=%0d done=%0d", hs_a - h0, dn_a - d0);
    endtask

    initial begin
        test_reset();
        test_full_bursts();
        test_round_up();
        test_arready_stall();
        test_zero_and_ignore();
        test_throttle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
